// File: rtl/id_fetch_queue_if.sv
// Handshake bundle between the imem response path (enq side) and the ID stage (deq side).
interface id_fetch_queue_if #(
  parameter int ORDER_W = 64
);
  logic               enq_valid;
  logic [31:0]        enq_inst;
  logic [31:0]        enq_pc;
  logic [ORDER_W-1:0] enq_order;
  logic               enq_ready;
  logic               deq_ready;
  logic               deq_valid;
  logic [31:0]        deq_inst;
  logic [31:0]        deq_pc;
  logic [ORDER_W-1:0] deq_order;
  logic [4:0]         rs1_s;
  logic [4:0]         rs2_s;

  modport master (
    output enq_valid, enq_inst, enq_pc, enq_order, deq_ready,
    input  enq_ready, deq_valid, deq_inst, deq_pc, deq_order, rs1_s, rs2_s
  );

  modport slave (
    input  enq_valid, enq_inst, enq_pc, enq_order, deq_ready,
    output enq_ready, deq_valid, deq_inst, deq_pc, deq_order, rs1_s, rs2_s
  );
endinterface

// File: rtl/id_fetch_queue.sv
// IF->ID instruction queue with flush/drain of one stale imem response.
// Optional same-cycle bypass on an empty queue: define ID_FETCH_QUEUE_BYPASS_EN.
module id_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     imem_busy,
  id_fetch_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

`ifdef ID_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [DEPTH-1:0][31:0]        inst_q;
  logic [DEPTH-1:0][31:0]        pc_q;
  logic [DEPTH-1:0][ORDER_W-1:0] order_q;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [0:0]    state_q, state_d;

  logic empty, full, run, byp;
  logic enq_fire, deq_fire, wr_en, rd_en;

  assign run   = (state_q == RUN);
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign count = wr_q - rd_q;

  // Bypass only ever shows a response the queue would have accepted anyway.
  assign byp = BYP && run && empty && bus.enq_valid && !flush;

  assign bus.enq_ready = run && !full;
  assign bus.deq_valid = (run && !empty) || byp;

  assign enq_fire = bus.enq_valid && bus.enq_ready && !flush;
  assign deq_fire = bus.deq_valid && bus.deq_ready && !flush;
  assign wr_en    = enq_fire && !(byp && bus.deq_ready);
  assign rd_en    = deq_fire && !byp;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    state_d = state_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      // A second flush while draining still owes exactly one discard.
      state_d = (state_q == DRAIN || imem_busy) ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      if (bus.enq_valid) state_d = RUN;
    end else begin
      if (wr_en) wr_d = wr_q + PW'(1);
      if (rd_en) rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      state_q <= RUN;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) begin
      inst_q[wr_q[AW-1:0]]  <= bus.enq_inst;
      pc_q[wr_q[AW-1:0]]    <= bus.enq_pc;
      order_q[wr_q[AW-1:0]] <= bus.enq_order;
    end
  end

  always_comb begin
    bus.deq_inst  = '0;
    bus.deq_pc    = '0;
    bus.deq_order = '0;
    if (run && !empty) begin
      bus.deq_inst  = inst_q[rd_q[AW-1:0]];
      bus.deq_pc    = pc_q[rd_q[AW-1:0]];
      bus.deq_order = order_q[rd_q[AW-1:0]];
    end else if (byp) begin
      bus.deq_inst  = bus.enq_inst;
      bus.deq_pc    = bus.enq_pc;
      bus.deq_order = bus.enq_order;
    end
  end

  assign bus.rs1_s = bus.deq_inst[19:15];
  assign bus.rs2_s = bus.deq_inst[24:20];
endmodule

// File: tb/tb_id_fetch_queue.sv
// Randomized + directed bench for id_fetch_queue against a queue-based reference model.
module tb_id_fetch_queue;
  localparam int DEPTH = 4;
  localparam int OW    = 64;
`ifdef ID_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] ord;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, imem_busy;
  logic [$clog2(DEPTH):0] count;

  id_fetch_queue_if #(.ORDER_W(OW)) bus();

  id_fetch_queue #(.DEPTH(DEPTH), .ORDER_W(OW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .imem_busy(imem_busy),
    .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_proto = 0;

  ent_t m_q[$];
  bit   m_drain;

  logic        c_fl, c_busy, c_ev, c_dr;
  ent_t        c_ent;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle and compare every output against the model.
  task automatic drive(input logic fl, input logic busy, input logic ev,
                       input logic [31:0] inst, input logic [31:0] pc,
                       input logic [63:0] ord, input logic dr);
    int   n;
    bit   byp, e_vld, e_rdy;
    ent_t h;
    @(negedge clk);
    flush = fl; imem_busy = busy; bus.enq_valid = ev; bus.deq_ready = dr;
    bus.enq_inst = inst; bus.enq_pc = pc; bus.enq_order = ord;
    c_fl = fl; c_busy = busy; c_ev = ev; c_dr = dr;
    c_ent.inst = inst; c_ent.pc = pc; c_ent.ord = ord;
    #1;
    n     = m_q.size();
    byp   = BYP && !m_drain && n == 0 && ev && !fl;
    e_rdy = !m_drain && n < DEPTH;
    e_vld = (!m_drain && n > 0) || byp;
    h.inst = '0; h.pc = '0; h.ord = '0;
    if (!m_drain && n > 0) h = m_q[0];
    else if (byp) h = c_ent;
    chk("enq_ready", bus.enq_ready, e_rdy);
    chk("deq_valid", bus.deq_valid, e_vld);
    chk("deq_inst", bus.deq_inst, h.inst);
    chk("deq_pc", bus.deq_pc, h.pc);
    chk("deq_order", bus.deq_order, h.ord);
    chk("rs1_s", bus.rs1_s, h.inst[19:15]);
    chk("rs2_s", bus.rs2_s, h.inst[24:20]);
    chk("count", count, n);
    assert (!(ev && !bus.enq_ready && !m_drain && !fl)) else n_proto++;
  endtask

  task automatic tick();
    int n;
    bit byp, do_deq, do_enq;
    @(posedge clk);
    n = m_q.size();
    if (c_fl) begin
      m_q.delete();
      m_drain = m_drain || c_busy;
    end else if (m_drain) begin
      if (c_ev) m_drain = 1'b0;
    end else begin
      byp    = BYP && n == 0 && c_ev;
      do_enq = c_ev && n < DEPTH;
      do_deq = c_dr && (n > 0 || byp);
      if (!(byp && c_dr)) begin
        if (do_deq) void'(m_q.pop_front());
        if (do_enq) m_q.push_back(c_ent);
      end
    end
  endtask

  task automatic step(input logic fl, input logic busy, input logic ev,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic [63:0] ord, input logic dr);
    drive(fl, busy, ev, inst, pc, ord, dr);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; imem_busy = 1'b0;
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b0;
    bus.enq_inst = '0; bus.enq_pc = '0; bus.enq_order = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_q.delete();
    m_drain = 1'b0;
  endtask

  localparam logic [31:0] BASE = 32'h1eceb000;

  initial begin
    do_reset();
    idle();
    chk("rst_count", count, 0);
    chk("rst_enq_ready", bus.enq_ready, 1);
    chk("rst_deq_valid", bus.deq_valid, 0);
    chk("rst_deq_inst", bus.deq_inst, 0);
    tick();

    // Single enqueue, 1-cycle visibility, register indices.
    step(0, 0, 1, 32'h00208093, BASE, 64'd7, 0);
    idle();
    chk("t1_valid", bus.deq_valid, 1);
    chk("t1_pc", bus.deq_pc, BASE);
    chk("t1_rs1", bus.rs1_s, 1);
    chk("t1_rs2", bus.rs2_s, 2);
    chk("t1_count", count, 1);
    tick();

    // Fill, then a 5th response while full is dropped even with a dequeue.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h13 + i, BASE + 4 * i, 64'(i), 0);
    idle();
    chk("t2_count_full", count, 4);
    chk("t2_enq_ready", bus.enq_ready, 0);
    tick();
    step(0, 0, 1, 32'h0badc0de, 32'h0bad0000, 64'd99, 1);
    idle();
    chk("t2_count", count, 3);
    chk("t2_head_pc", bus.deq_pc, BASE + 4);
    tick();
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);

    // Streaming through 10 entries wraps the pointers more than once.
    do_reset();
    step(0, 0, 1, 32'h13, BASE, 64'd0, 0);
    for (int i = 1; i < 10; i++) begin
      drive(0, 0, 1, 32'h13, BASE + 4 * i, 64'(i), 1);
      chk("t3_pc", bus.deq_pc, BASE + 4 * (i - 1));
      chk("t3_count", count, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_last_pc", bus.deq_pc, BASE + 32'h24);
    tick();

    // Flush with a request outstanding: the next response is stale.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h13, BASE + 4 * i, 64'(i), 0);
    step(1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'hdeadbeef, 32'h1000, 64'd50, 1);
    chk("t4_drain_valid", bus.deq_valid, 0);
    chk("t4_drain_ready", bus.enq_ready, 0);
    tick();
    step(0, 0, 1, 32'h00000013, 32'h2000, 64'd51, 0);
    idle();
    chk("t4_valid", bus.deq_valid, 1);
    chk("t4_inst", bus.deq_inst, 32'h13);
    chk("t4_count", count, 1);
    tick();

    // Flush without outstanding request beats same-cycle enq and deq.
    do_reset();
    for (int i = 0; i < 2; i++) step(0, 0, 1, 32'h13, BASE + 4 * i, 64'(i), 0);
    step(1, 0, 1, 32'h00100093, 32'h3000, 64'd60, 1);
    idle();
    chk("t5_count", count, 0);
    chk("t5_valid", bus.deq_valid, 0);
    chk("t5_run", bus.enq_ready, 1);
    tick();
    step(0, 0, 1, 32'h13, 32'h3004, 64'd61, 0);
    idle();
    chk("t5_count_after", count, 1);
    tick();

    // Empty queue, enqueue and dequeue together.
    do_reset();
    drive(0, 0, 1, 32'h00500113, 32'h4000, 64'd70, 1);
`ifdef ID_FETCH_QUEUE_BYPASS_EN
    chk("t6_byp_valid", bus.deq_valid, 1);
    chk("t6_byp_inst", bus.deq_inst, 32'h00500113);
    chk("t6_byp_rs1", bus.rs1_s, 0);
    tick();
    idle();
    chk("t6_byp_count", count, 0);
`else
    chk("t6_nobyp_valid", bus.deq_valid, 0);
    tick();
    idle();
    chk("t6_nobyp_count", count, 1);
    chk("t6_nobyp_inst", bus.deq_inst, 32'h00500113);
`endif
    tick();

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic fl, busy, ev, dr;
      fl   = ($urandom_range(0, 15) == 0);
      busy = $urandom_range(0, 1);
      ev   = ($urandom_range(0, 2) != 0);
      dr   = ($urandom_range(0, 1) == 1);
      step(fl, busy, ev, $urandom, $urandom & 32'hffff_fffc, {$urandom, $urandom}, dr);
    end

    $display("protocol-violation cycles driven: %0d", n_proto);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
